// File: rtl/fixed_to_float_iter.sv
// fixed_to_float_iter
// -------------------
// Converts a signed fixed-point word (Q2.19 by default) into an IEEE-754
// single-precision value. The conversion runs over several cycles. The
// magnitude is shifted left one bit per cycle until its MSB is set, and the
// number of shifts is counted. That count then gives the exponent directly.
// Every representable input fits in the 24-bit significand, so the result
// is always exact and no rounding stage is required.
//
// Ports
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset; clears state, done, result
//   clk_en  : global enable; all registers hold while low
//   start   : conversion request, accepted only in IDLE
//   dataa   : operand; bits [WIDTH-1:0] hold the fixed-point value
//   done    : one-cycle pulse; result is valid in this cycle
//   busy    : high whenever the converter is not in IDLE
//   result  : IEEE-754 single; held until the next conversion completes
module fixed_to_float_iter #(
    parameter int WIDTH     = 21,
    parameter int FRAC_BITS = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic        busy,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] PACK = 2'd2;

    // An input with its MSB already set (s = 0) has the exponent
    // 127 + integer bits.
    localparam int          EXP_TOP  = 127 + (WIDTH - 1 - FRAC_BITS);
    localparam logic [7:0]  EXP_BASE = 8'(EXP_TOP);
    localparam logic [WIDTH-1:0] ZERO_W = '0;

    logic [1:0]       state_reg, state_next;
    logic             sign_reg, sign_next;
    logic [WIDTH-1:0] mag_reg, mag_next;
    logic [4:0]       s_reg, s_next;
    logic [31:0]      result_reg, result_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] mag_in;
    logic [7:0]       exp_val;
    logic [22:0]      mant_val;
    logic             unused_bits;

    assign raw = dataa[WIDTH-1:0];

    // The upper operand bits do not affect the conversion.
    assign unused_bits = ^dataa[31:WIDTH];

    // The magnitude register is unsigned. The most negative input therefore
    // becomes 2^(WIDTH-1) without overflowing.
    assign mag_in = raw[WIDTH-1] ? (ZERO_W - raw) : raw;

    assign exp_val = EXP_BASE - {3'b000, s_reg};

    // The hidden bit mag[WIDTH-1] is dropped. The remaining bits are
    // left-aligned into the 23-bit fraction field.
    assign mant_val = 23'(mag_reg[WIDTH-2:0]) << (24 - WIDTH);

    always_comb begin
        state_next  = state_reg;
        sign_next   = sign_reg;
        mag_next    = mag_reg;
        s_next      = s_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_next = raw[WIDTH-1];
                    mag_next  = mag_in;
                    s_next    = 5'd0;
                    if (mag_in == ZERO_W) begin
                        // A zero input finishes at once as +0.
                        result_next = 32'h0000_0000;
                        done_next   = 1'b1;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_reg[WIDTH-1]) begin
                    state_next = PACK;
                end else begin
                    mag_next = mag_reg << 1;
                    s_next   = s_reg + 5'd1;
                end
            end
            PACK: begin
                result_next = {sign_reg, exp_val, mant_val};
                done_next   = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            sign_reg   <= 1'b0;
            mag_reg    <= '0;
            s_reg      <= 5'd0;
            result_reg <= 32'h0000_0000;
            done_reg   <= 1'b0;
        end else if (clk_en) begin
            state_reg  <= state_next;
            sign_reg   <= sign_next;
            mag_reg    <= mag_next;
            s_reg      <= s_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    assign done   = done_reg;
    assign busy   = (state_reg != IDLE);
    assign result = result_reg;

endmodule
